hazard_stall_ctrl: RTL and testbench

Central stall/flush controller for the 5-stage pipeline. It is the producer side of the hazard path: the forwarding unit resolves every RAW case except load-use, and this block generates the freeze/bubble/flush controls it cannot. It also handles data-memory wait handshakes, branch-redirect flushes, a wait-timeout error and a stall performance counter.

---
 rtl/hazard_stall_ctrl_if.sv | 44 ++++
 rtl/hazard_stall_ctrl.sv | 84 ++++++++
 tb/tb_hazard_stall_ctrl.sv | 182 ++++++++++++++++++
 3 files changed

// File: rtl/hazard_stall_ctrl_if.sv
// Pipeline <-> hazard controller bundle: hazard inputs from IF/ID, ID/EX, EX/MEM
// and data memory, plus the freeze/bubble/flush controls and status going back.
interface hazard_stall_ctrl_if #(
  parameter int REG_W = 5,
  parameter int CNT_W = 32
);
  logic [REG_W-1:0] ifid_rs1;
  logic [REG_W-1:0] ifid_rs2;
  logic             ifid_uses_rs1;
  logic             ifid_uses_rs2;
  logic [REG_W-1:0] idex_rd;
  logic             idex_memread;
  logic             exmem_memread;
  logic             exmem_memwrite;
  logic             dmem_ready;
  logic             ex_branch_taken;

  logic             pc_stall;
  logic             ifid_stall;
  logic             ifid_flush;
  logic             idex_bubble;
  logic             idex_stall;
  logic             exmem_stall;
  logic             memwb_bubble;
  logic             in_memwait;
  logic             mem_timeout;
  logic [CNT_W-1:0] stall_cycles;

  modport master (
    output ifid_rs1, ifid_rs2, ifid_uses_rs1, ifid_uses_rs2, idex_rd,
           idex_memread, exmem_memread, exmem_memwrite, dmem_ready,
           ex_branch_taken,
    input  pc_stall, ifid_stall, ifid_flush, idex_bubble, idex_stall,
           exmem_stall, memwb_bubble, in_memwait, mem_timeout, stall_cycles
  );

  modport slave (
    input  ifid_rs1, ifid_rs2, ifid_uses_rs1, ifid_uses_rs2, idex_rd,
           idex_memread, exmem_memread, exmem_memwrite, dmem_ready,
           ex_branch_taken,
    output pc_stall, ifid_stall, ifid_flush, idex_bubble, idex_stall,
           exmem_stall, memwb_bubble, in_memwait, mem_timeout, stall_cycles
  );
endinterface

// File: rtl/hazard_stall_ctrl.sv
// Stall/flush controller for the 5-stage pipeline: load-use bubbles, dmem wait
// freezes, branch flushes, a sticky wait-timeout flag and a stall counter.
module hazard_stall_ctrl #(
  parameter int REG_W      = 5,
  parameter int WAIT_LIMIT = 64,
  parameter int CNT_W      = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  hazard_stall_ctrl_if.slave hz
);
  localparam int WC_W = $clog2(WAIT_LIMIT + 1);

  typedef enum logic {RUN, MEMWAIT} state_t;

  state_t          state, state_nxt;
  logic [WC_W-1:0] wait_cnt;
  logic            mem_req, freeze, loaduse, rs1_hit, rs2_hit;

  assign mem_req = hz.exmem_memread | hz.exmem_memwrite;
  assign freeze  = mem_req & ~hz.dmem_ready;
  assign rs1_hit = hz.ifid_uses_rs1 & (hz.ifid_rs1 == hz.idex_rd);
  assign rs2_hit = hz.ifid_uses_rs2 & (hz.ifid_rs2 == hz.idex_rd);
  assign loaduse = hz.idex_memread & (hz.idex_rd != '0) & (rs1_hit | rs2_hit);

  // Controls are held at zero while rst_n is low, not just once state resets.
  always_comb begin
    hz.pc_stall     = 1'b0;
    hz.ifid_stall   = 1'b0;
    hz.ifid_flush   = 1'b0;
    hz.idex_bubble  = 1'b0;
    hz.idex_stall   = 1'b0;
    hz.exmem_stall  = 1'b0;
    hz.memwb_bubble = 1'b0;
    if (rst_n) begin
      if (freeze) begin
        hz.pc_stall     = 1'b1;
        hz.ifid_stall   = 1'b1;
        hz.idex_stall   = 1'b1;
        hz.exmem_stall  = 1'b1;
        hz.memwb_bubble = 1'b1;
      end else if (hz.ex_branch_taken) begin
        hz.ifid_flush  = 1'b1;
        hz.idex_bubble = 1'b1;
      end else if (loaduse) begin
        hz.pc_stall    = 1'b1;
        hz.ifid_stall  = 1'b1;
        hz.idex_bubble = 1'b1;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      RUN:     if (freeze)  state_nxt = MEMWAIT;
      MEMWAIT: if (!freeze) state_nxt = RUN;
      default: state_nxt = RUN;
    endcase
  end

  assign hz.in_memwait = (state == MEMWAIT);

  // wait_cnt also counts the first frozen cycle (still in RUN), so the flag
  // rises on the edge closing the WAIT_LIMIT-th consecutive frozen cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state           <= RUN;
      wait_cnt        <= '0;
      hz.mem_timeout  <= 1'b0;
      hz.stall_cycles <= '0;
    end else begin
      state <= state_nxt;
      if (!freeze)
        wait_cnt <= '0;
      else if (wait_cnt != WC_W'(WAIT_LIMIT))
        wait_cnt <= wait_cnt + 1'b1;
      if (freeze && wait_cnt == WC_W'(WAIT_LIMIT - 1))
        hz.mem_timeout <= 1'b1;
      if (hz.pc_stall && hz.stall_cycles != '1)
        hz.stall_cycles <= hz.stall_cycles + 1'b1;
    end
  end
endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Directed bench for hazard_stall_ctrl; a narrow stall counter exposes saturation.
module tb_hazard_stall_ctrl;
  localparam int REG_W = 5;
  localparam int CNT_W = 4;
  localparam int WAIT_LIMIT = 64;

  // {pc_stall, ifid_stall, ifid_flush, idex_bubble, idex_stall, exmem_stall, memwb_bubble}
  localparam logic [6:0] NONE = 7'b0000000;
  localparam logic [6:0] FRZ  = 7'b1100111;
  localparam logic [6:0] LU   = 7'b1101000;
  localparam logic [6:0] BR   = 7'b0011000;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_checks = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  hazard_stall_ctrl_if #(.REG_W(REG_W), .CNT_W(CNT_W)) hz ();

  hazard_stall_ctrl #(.REG_W(REG_W), .WAIT_LIMIT(WAIT_LIMIT), .CNT_W(CNT_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .hz    (hz.slave)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_ctl(input string tag, input logic [6:0] exp);
    chk(tag, {25'd0, hz.pc_stall, hz.ifid_stall, hz.ifid_flush, hz.idex_bubble,
              hz.idex_stall, hz.exmem_stall, hz.memwb_bubble}, {25'd0, exp});
  endtask

  task automatic clr;
    hz.ifid_rs1 = '0; hz.ifid_rs2 = '0;
    hz.ifid_uses_rs1 = 1'b0; hz.ifid_uses_rs2 = 1'b0;
    hz.idex_rd = '0; hz.idex_memread = 1'b0;
    hz.exmem_memread = 1'b0; hz.exmem_memwrite = 1'b0;
    hz.dmem_ready = 1'b0; hz.ex_branch_taken = 1'b0;
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic set_lu(input logic [4:0] rd, input logic [4:0] rs1, input logic u1,
                        input logic [4:0] rs2, input logic u2);
    hz.idex_memread = 1'b1; hz.idex_rd = rd;
    hz.ifid_rs1 = rs1; hz.ifid_uses_rs1 = u1;
    hz.ifid_rs2 = rs2; hz.ifid_uses_rs2 = u2;
  endtask

  initial begin
    clr();
    // Reset with a pending freeze on the inputs: controls must still be zero.
    hz.exmem_memread = 1'b1;
    #2;
    chk_ctl("reset_ctl", NONE);
    chk("reset_sc", 32'(hz.stall_cycles), 32'd0);
    chk("reset_memwait", 32'(hz.in_memwait), 32'd0);
    chk("reset_timeout", 32'(hz.mem_timeout), 32'd0);
    clr();
    tick();
    rst_n = 1'b1;
    #1;
    chk_ctl("idle_ctl", NONE);

    // Load x5 in EX, ID uses rs2 = x5.
    set_lu(5'd5, 5'd3, 1'b1, 5'd5, 1'b1);
    #1 chk_ctl("lu_rs2", LU);
    tick();
    hz.idex_memread = 1'b0;
    #1 chk_ctl("lu_release", NONE);
    chk("lu_sc", 32'(hz.stall_cycles), 32'd1);

    // rd = x0 and unused-source matches never stall.
    set_lu(5'd0, 5'd0, 1'b1, 5'd0, 1'b1);
    #1 chk_ctl("lu_x0", NONE);
    set_lu(5'd7, 5'd7, 1'b0, 5'd7, 1'b0);
    #1 chk_ctl("lu_unused", NONE);
    tick();

    // Load-use together with a taken branch: flush wins, no stall counted.
    set_lu(5'd9, 5'd9, 1'b1, 5'd1, 1'b1);
    hz.ex_branch_taken = 1'b1;
    #1 chk_ctl("lu_vs_branch", BR);
    tick();
    chk("branch_sc", 32'(hz.stall_cycles), 32'd1);
    hz.ex_branch_taken = 1'b0;

    // Both sources match: a single one-cycle stall.
    set_lu(5'd12, 5'd12, 1'b1, 5'd12, 1'b1);
    #1 chk_ctl("lu_both", LU);
    tick();
    hz.idex_memread = 1'b0;
    #1 chk_ctl("lu_both_rel", NONE);
    chk("lu_both_sc", 32'(hz.stall_cycles), 32'd2);
    clr();

    // Three-cycle dmem wait with a branch pending in EX.
    hz.exmem_memread = 1'b1; hz.ex_branch_taken = 1'b1;
    #1 chk_ctl("frz_c1", FRZ);
    chk("frz_c1_mw", 32'(hz.in_memwait), 32'd0);
    tick();
    chk_ctl("frz_c2", FRZ);
    chk("frz_c2_mw", 32'(hz.in_memwait), 32'd1);
    tick();
    chk_ctl("frz_c3", FRZ);
    chk("frz_c3_mw", 32'(hz.in_memwait), 32'd1);
    tick();
    hz.dmem_ready = 1'b1;
    #1 chk_ctl("frz_c4_release", BR);
    chk("frz_c4_mw", 32'(hz.in_memwait), 32'd1);
    tick();
    chk("frz_sc", 32'(hz.stall_cycles), 32'd5);
    chk("frz_back_run", 32'(hz.in_memwait), 32'd0);
    clr();

    // Wait timeout: 64 consecutive frozen cycles. Counter saturates at 15.
    hz.exmem_memwrite = 1'b1;
    for (int i = 0; i < WAIT_LIMIT - 1; i++) tick();
    chk("to_not_yet", 32'(hz.mem_timeout), 32'd0);
    chk_ctl("to_still_frz", FRZ);
    tick();
    chk("to_set", 32'(hz.mem_timeout), 32'd1);
    chk_ctl("to_frz_after", FRZ);
    chk("sc_sat", 32'(hz.stall_cycles), 32'd15);
    hz.dmem_ready = 1'b1;
    #1 chk_ctl("to_release", NONE);
    tick();
    chk("to_run", 32'(hz.in_memwait), 32'd0);
    chk("to_sticky", 32'(hz.mem_timeout), 32'd1);
    clr();
    set_lu(5'd2, 5'd2, 1'b1, 5'd0, 1'b0);
    tick();
    clr();
    chk("sc_nowrap", 32'(hz.stall_cycles), 32'd15);

    // Asynchronous reset in the middle of a wait.
    hz.exmem_memread = 1'b1;
    tick();
    tick();
    chk("pre_rst_mw", 32'(hz.in_memwait), 32'd1);
    #2 rst_n = 1'b0;
    #1 chk_ctl("async_rst_ctl", NONE);
    chk("async_rst_mw", 32'(hz.in_memwait), 32'd0);
    chk("async_rst_to", 32'(hz.mem_timeout), 32'd0);
    chk("async_rst_sc", 32'(hz.stall_cycles), 32'd0);
    clr();
    tick();
    rst_n = 1'b1;
    tick();
    chk("post_rst_mw", 32'(hz.in_memwait), 32'd0);
    chk("post_rst_sc", 32'(hz.stall_cycles), 32'd0);

    // Back-to-back loads, each with its own dependent instruction.
    set_lu(5'd4, 5'd4, 1'b1, 5'd0, 1'b0);
    #1 chk_ctl("b2b_lu1", LU);
    tick();
    hz.idex_memread = 1'b0;
    #1 chk_ctl("b2b_gap", NONE);
    tick();
    set_lu(5'd6, 5'd1, 1'b1, 5'd6, 1'b1);
    #1 chk_ctl("b2b_lu2", LU);
    tick();
    hz.idex_memread = 1'b0;
    #1 chk_ctl("b2b_done", NONE);
    chk("b2b_sc", 32'(hz.stall_cycles), 32'd2);
    chk("b2b_to", 32'(hz.mem_timeout), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
